// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: opcode encodings,
// FSM state and grant enums, and the round-robin grant helper.
package mem_arb_pkg;

  // MEM-stage opcodes that need the RAM port
  localparam logic [4:0] OP_LOAD  = 5'd10;
  localparam logic [4:0] OP_STORE = 5'd6;

  // Wait counter width; large enough for RAM_LAT up to 15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  // Round-robin pick: a lone requester wins; on a tie the requester that
  // was not served last wins.
  function automatic grant_t pick_grant(input logic   mem_req,
                                        input logic   if_req,
                                        input grant_t last_grant);
    grant_t g;
    g = GRANT_IF;
    if (mem_req && if_req) begin
      g = (last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
    end else if (mem_req) begin
      g = GRANT_MEM;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of the MEM-stage opcode into a RAM request and a
// store flag. Any opcode other than load/store is a no-access.
module mem_op_decode
  import mem_arb_pkg::*;
(
  input  logic [4:0] mem_opcode,
  output logic       mem_req,
  output logic       is_store
);

  // Decode load/store; everything else requests nothing
  always_comb begin
    is_store = (mem_opcode == OP_STORE);
    mem_req  = (mem_opcode == OP_LOAD) || (mem_opcode == OP_STORE);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared RAM port between instruction fetch and the
// MEM stage. One access at a time runs IDLE -> ISSUE -> (WAIT) -> DONE;
// loads and fetches wait RAM_LAT cycles for read data, stores complete
// straight after issue. Stalls are combinational so a requester is held
// until the cycle its done/valid pulse appears.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mem_opcode,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_mem,
  output logic              stall_if
);

  logic mem_req;
  logic dec_is_store;
  grant_t win;

  arb_state_t        state_q, state_d;
  grant_t            grant_q, grant_d;
  grant_t            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_store_q, is_store_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;

  mem_op_decode u_decode (
    .mem_opcode (mem_opcode),
    .mem_req    (mem_req),
    .is_store   (dec_is_store)
  );

  assign win = pick_grant(mem_req, if_req, last_grant_q);

  // State, latched request and read-data registers; reset aborts any access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_store_q   <= 1'b0;
      cnt_q        <= '0;
      mem_rdata_q  <= '0;
      if_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_store_q   <= is_store_d;
      cnt_q        <= cnt_d;
      mem_rdata_q  <= mem_rdata_d;
      if_rdata_q   <= if_rdata_d;
    end
  end

  // Next-state logic and RAM strobes/pulses for the access sequencer
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    is_store_d   = is_store_q;
    cnt_d        = cnt_q;
    mem_rdata_d  = mem_rdata_q;
    if_rdata_d   = if_rdata_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    mem_done     = 1'b0;
    if_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req || if_req) begin
          grant_d = win;
          if (win == GRANT_MEM) begin
            addr_d     = mem_addr;
            wdata_d    = mem_wdata;
            is_store_d = dec_is_store;
          end else begin
            addr_d     = if_addr;
            wdata_d    = '0;
            is_store_d = 1'b0;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        ram_en = 1'b1;
        ram_we = is_store_q;
        if (is_store_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(RAM_LAT);
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Read data is valid in the last counted cycle
        if (cnt_q == CNT_W'(1)) begin
          if (grant_q == GRANT_MEM) begin
            mem_rdata_d = ram_rdata;
          end else begin
            if_rdata_d = ram_rdata;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        mem_done     = (grant_q == GRANT_MEM);
        if_valid     = (grant_q == GRANT_IF);
        last_grant_d = grant_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_rdata  = if_rdata_q;

  // A requester stays held until the cycle its completion pulse shows
  assign stall_mem = mem_req & ~mem_done;
  assign stall_if  = if_req & ~if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a latency-accurate
// RAM model and a transaction-level reference for grant order, timing and data.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    mem_opcode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          stall_mem;
  logic          stall_if;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .if_req(if_req), .if_addr(if_addr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .stall_mem(stall_mem), .stall_if(stall_if)
  );

  // RAM model: read data appears exactly LAT cycles after the strobe,
  // random junk otherwise so an early or late capture is visible.
  logic [DW-1:0] ram [256];
  logic          pv [LAT];
  logic [7:0]    pa [LAT];
  logic [DW-1:0] junk = '0;
  logic          pre_we = 1'b0;
  logic [7:0]    pre_a  = '0;
  logic [DW-1:0] pre_d  = '0;

  always @(posedge clk) begin
    junk <= $urandom;
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ram_en && ram_we) ram[ram_addr[7:0]] <= ram_wdata;
    pv[0] <= ram_en && !ram_we && !rst;
    pa[0] <= ram_addr[7:0];
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1] && !rst;
      pa[i] <= pa[i-1];
    end
  end

  assign ram_rdata = pv[LAT-1] ? ram[pa[LAT-1]] : junk;

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  bit            last_mem;
  logic [DW-1:0] hold_mrd;
  logic [DW-1:0] hold_ird;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] nop_op();
    logic [4:0] v;
    v = 5'($urandom_range(0, 31));
    if (v == 5'd6 || v == 5'd10) v = 5'd3;
    return v;
  endfunction

  task automatic drive_idle();
    mem_opcode = nop_op();
    mem_addr   = $urandom;
    mem_wdata  = $urandom;
    if_req     = 1'b0;
    if_addr    = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
    #1;
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_mem_done", mem_done, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_mem = 1'b0;
    hold_mrd = '0;
    hold_ird = '0;
    $display("reset applied");
  endtask

  // One transaction: optional MEM access and optional fetch presented together.
  task automatic run_txn(input bit m_act, input bit m_st, input logic [7:0] m_a,
                         input logic [31:0] m_d, input bit i_act, input logic [7:0] i_a);
    int l_mem, l_if, t_mem, t_if, iss_mem, iss_if, end_c;
    bit mem_first, exp_en, exp_we;
    logic [31:0] new_mrd, new_ird, e_mrd, e_ird, e_addr;
    l_mem = m_st ? 2 : LAT + 2;
    l_if  = LAT + 2;
    t_mem = -1; t_if = -1; iss_mem = -1; iss_if = -1;
    mem_first = m_act && (!i_act || !last_mem);
    if (m_act && i_act) begin
      if (mem_first) begin
        iss_mem = 1; t_mem = l_mem; iss_if = t_mem + 2; t_if = t_mem + 1 + l_if;
      end else begin
        iss_if = 1; t_if = l_if; iss_mem = t_if + 2; t_mem = t_if + 1 + l_mem;
      end
    end else if (m_act) begin
      iss_mem = 1; t_mem = l_mem;
    end else if (i_act) begin
      iss_if = 1; t_if = l_if;
    end
    // Apply accesses to the reference memory in grant order
    new_mrd = hold_mrd;
    new_ird = hold_ird;
    if (mem_first) begin
      if (m_st) ref_mem[m_a] = m_d; else new_mrd = ref_mem[m_a];
      if (i_act) new_ird = ref_mem[i_a];
    end else begin
      if (i_act) new_ird = ref_mem[i_a];
      if (m_act) begin
        if (m_st) ref_mem[m_a] = m_d; else new_mrd = ref_mem[m_a];
      end
    end
    end_c = (t_mem > t_if) ? t_mem : t_if;
    if (end_c < 0) end_c = 2;

    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk); #1;
      drive_idle();
      if (m_act && c <= t_mem) begin
        mem_opcode = m_st ? 5'd6 : 5'd10;
        mem_addr   = {24'h0, m_a};
        mem_wdata  = m_d;
      end
      if (i_act && c <= t_if) begin
        if_req  = 1'b1;
        if_addr = {24'h0, i_a};
      end
      @(negedge clk);
      chk("mem_done", mem_done, m_act && c == t_mem);
      chk("if_valid", if_valid, i_act && c == t_if);
      exp_en = (m_act && c == iss_mem) || (i_act && c == iss_if);
      exp_we = m_act && m_st && c == iss_mem;
      chk("ram_en", ram_en, exp_en);
      chk("ram_we", ram_we, exp_we);
      if (exp_en) begin
        e_addr = (m_act && c == iss_mem) ? {24'h0, m_a} : {24'h0, i_a};
        chk("ram_addr", ram_addr, e_addr);
        if (exp_we) chk("ram_wdata", ram_wdata, m_d);
      end
      chk("stall_mem", stall_mem, m_act && c <= t_mem && c != t_mem);
      chk("stall_if", stall_if, i_act && c <= t_if && c != t_if);
      e_mrd = (m_act && !m_st && c >= t_mem) ? new_mrd : hold_mrd;
      e_ird = (i_act && c >= t_if) ? new_ird : hold_ird;
      chk("mem_rdata", mem_rdata, e_mrd);
      chk("if_rdata", if_rdata, e_ird);
    end
    hold_mrd = new_mrd;
    hold_ird = new_ird;
    if (m_act && i_act) last_mem = !mem_first;
    else if (m_act) last_mem = 1'b1;
    else if (i_act) last_mem = 1'b0;
    $display("txn mem=%0d st=%0d maddr=%h if=%0d iaddr=%h mem_first=%0d t_mem=%0d t_if=%0d",
             m_act, m_st, m_a, i_act, i_a, mem_first, t_mem, t_if);
  endtask

  // Reset arriving while a load is waiting on RAM data
  task automatic reset_mid_wait(input logic [7:0] a);
    @(posedge clk); #1;
    drive_idle();
    mem_opcode = 5'd10;
    mem_addr   = {24'h0, a};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_no_done", mem_done, 1'b0);
      if (c < 2) @(posedge clk);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("mid_ram_en", ram_en, 1'b0);
    chk("mid_mem_done", mem_done, 1'b0);
    chk("mid_mem_rdata", mem_rdata, 32'h0);
    chk("mid_if_rdata", if_rdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_done", mem_done, 1'b0);
      chk("mid_rst_en", ram_en, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    last_mem = 1'b0;
    hold_mrd = '0;
    hold_ird = '0;
    @(negedge clk);
    chk("post_rst_done", mem_done, 1'b0);
    $display("reset mid-wait addr=%h", a);
    run_txn(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    // Preload RAM and reference with identical contents
    for (int a = 0; a < 256; a++) begin
      @(posedge clk); #1;
      pre_we = 1'b1;
      pre_a  = 8'(a);
      pre_d  = (a == 16) ? 32'hDEADBEEF : $urandom;
      ref_mem[a] = pre_d;
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    do_reset();

    // Directed cases
    run_txn(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 8'h0);
    chk("deadbeef", mem_rdata, 32'hDEADBEEF);
    run_txn(1'b1, 1'b1, 8'h20, 32'h15, 1'b0, 8'h0);
    run_txn(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 8'h0);
    chk("store_readback", mem_rdata, 32'h15);
    run_txn(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0);

    do_reset();
    run_txn(1'b1, 1'b0, 8'h40, 32'h0, 1'b1, 8'h44);
    run_txn(1'b1, 1'b1, 8'h48, 32'hCAFE0001, 1'b1, 8'h48);
    run_txn(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 8'h48);
    chk("fetch_after_store", if_rdata, 32'hCAFE0001);

    reset_mid_wait(8'h30);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
              $urandom, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
